end_screen_sequencer: RTL
=========================

# end_screen_sequencer

Parametrised end-of-game overlay controller and compositor. It sits between the game FSM and the top-level pixel mux. On game end it latches the final score and updates a persistent high-score register. It then animates a score tally, one step per frame, and shows high-score and "new record" layers with blinking. Up to N_LAYERS externally rendered sprite layers are composited by fixed priority and per-state visibility.

## Interface
- SCORE_W, 12: score width in bits.
- N_LAYERS, 4: number of sprite layers, minimum 4. Layer 0 is the label, 1 is the tally digits, 2 is the high-score digits, 3 is the new-record badge. Layers 4 and above are decorations.
- TALLY_STEP, 7: tally increment per frame; must be at least 1.
- BLINK_FRAMES, 16: frames per badge blink half-period; must be at least 1.

Ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  pixel clock.
- i_rst  in  1  synchronous reset, active-high.
- i_v_sync  in  1  vertical sync. A frame tick is a 0→1 transition sampled on i_clk.
- i_is_end  in  1  game-over level from the FSM.
- i_score  in  SCORE_W  final score from the score compositor.
- i_layer_rgb  in  24*N_LAYERS  per-layer {r,g,b}; layer k is at bits [24k+23:24k].
- i_layer_hit  in  N_LAYERS  per-layer sprite hit.
- o_tally_value  out  SCORE_W  value that drives the layer 1 digit renderer.
- o_high_score  out  SCORE_W  value that drives the layer 2 digit renderer.
- o_new_record  out  1  the last game set a new high score.
- o_done  out  1  the tally is complete (state SHOW).
- o_red, o_green, o_blue  out  8 each  composited colour.
- o_sprite_hit  out  1  the overlay owns this pixel.

## Operation
- States: IDLE, LATCH, TALLY, SHOW.
- IDLE:
  - Nothing is visible; o_sprite_hit=0.
  - A rising edge of i_is_end moves to LATCH. The edge register resets to 0, so i_is_end already high after reset counts as a rise.
- LATCH (1 cycle):
  - score_q ← i_score; tally ← 0.
  - If i_score > high_score (strict), then high_score ← i_score and new_record ← 1; otherwise new_record ← 0.
  - Next state is TALLY.
- TALLY:
  - On each frame tick: tally ← min(tally+TALLY_STEP, score_q). The sum is computed in SCORE_W+1 bits, so it never wraps.
  - When tally == score_q (checked every cycle), move to SHOW. A score of 0 therefore reaches SHOW in the cycle after LATCH.
- SHOW:
  - o_done=1.
  - blink_cnt counts frame ticks; it wraps at BLINK_FRAMES-1 and toggles blink_ph when it wraps. blink_ph=1 (visible) on SHOW entry.
- From LATCH, TALLY or SHOW: i_is_end=0 → IDLE. This takes priority over every other transition and over frame ticks in the same cycle. tally is cleared to 0. high_score and new_record are retained.
- Layer visibility mask:
  - Layer 0 and layers 4 and above: all states except IDLE.
  - Layer 1: TALLY and SHOW.
  - Layer 2: SHOW only.
  - Layer 3: SHOW, new_record=1 and blink_ph=1.
- Compositing:
  - The lowest-index layer with hit & visible wins.
  - o_sprite_hit = OR over k of (hit_k & visible_k).
  - When no layer wins, the RGB outputs are 0. They are never X.
- The block takes no clock enable. Frame ticks are its only time base.

## Timing
- Reset values:
  - State: IDLE.
  - tally, score_q, high_score: 0.
  - new_record, o_done, blink_ph, blink_cnt: 0.
  - The v_sync and is_end edge registers: 0.
- Control state, o_tally_value, o_high_score, o_new_record and o_done are registered; they change one cycle after the causing edge is sampled.
- Pixel path: combinational from i_layer_* and registered state, with zero latency. Renderers are pixel-aligned upstream.
- A frame tick coinciding with the LATCH cycle is ignored.
- A second i_is_end rise (after a fall) starts a new game sequence; high_score carries over.
- i_rst mid-sequence: back to IDLE next cycle, and high_score is cleared.

## Structure
- The shared package `end_screen_pkg` holds:
  - The state enum (IDLE, LATCH, TALLY, SHOW).
  - Layer index constants (LYR_LABEL=0, LYR_TALLY=1, LYR_HIGH=2, LYR_BADGE=3).
- Sub-module `layer_priority_mux`, parametrised by N_LAYERS: takes hit, visible mask and rgb, and returns the winning rgb and the hit flag.
- The sequencer FSM and counters live in the top module.

## Test plan
- Reset, then i_is_end=1 and i_score=100, with a v_sync tick every 1000 cycles. Expect o_tally_value 0,7,14,…,98,100 on successive ticks; o_done=1 after 15 ticks; o_high_score=100; o_new_record=1.
- Second game with i_score=50. Expect o_high_score=100, o_new_record=0, and layer 3 never visible even when its hit is forced to 1.
- i_score=0. Expect SHOW (o_done=1) two cycles after the is_end rise, with no frame tick needed.
- In SHOW with new_record=1 and BLINK_FRAMES=4, layer 3 hit held at 1. Expect the badge visible for 4 ticks, hidden for 4, visible again. In IDLE expect o_sprite_hit=0 and rgb=0.
- Overlap: layers 0 and 1 hit together in TALLY. Expect layer 0's colour. Layer 2 hit alone in TALLY gives o_sprite_hit=0.
- i_is_end falls in the same cycle as a tick during TALLY. Expect IDLE next cycle, tally=0, and high_score retained. Asserting i_rst mid-TALLY clears high_score.

Source files
------------

// File: rtl/end_screen_pkg.sv
// Shared types for the end-of-game overlay: sequencer states and layer roles.
package end_screen_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_TALLY = 2'd2,
    ST_SHOW  = 2'd3
  } state_t;

  localparam int LYR_LABEL = 0;
  localparam int LYR_TALLY = 1;
  localparam int LYR_HIGH  = 2;
  localparam int LYR_BADGE = 3;
endpackage

// File: rtl/end_screen_sequencer_layer_priority_mux.sv
// Fixed-priority compositor: lowest-index visible hit wins, black otherwise.
module layer_priority_mux #(
  parameter int N_LAYERS = 4
) (
  input  logic [N_LAYERS-1:0]       i_hit,
  input  logic [N_LAYERS-1:0]       i_vis,
  input  logic [N_LAYERS-1:0][23:0] i_rgb,
  output logic [23:0]               o_rgb,
  output logic                      o_hit
);
  logic [N_LAYERS-1:0] w_live;

  assign w_live = i_hit & i_vis;
  assign o_hit  = |w_live;

  // Walk from the top down so the lowest live index is written last.
  always_comb begin
    o_rgb = '0;
    for (int k = N_LAYERS-1; k >= 0; k--) begin
      if (w_live[k]) o_rgb = i_rgb[k];
    end
  end
endmodule

// File: rtl/end_screen_sequencer.sv
// End-of-game sequencer: latches score, tracks high score, animates the tally
// per frame and drives the layer visibility for the overlay compositor.
module end_screen_sequencer
  import end_screen_pkg::*;
#(
  parameter int SCORE_W      = 12,
  parameter int N_LAYERS     = 4,
  parameter int TALLY_STEP   = 7,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_v_sync,
  input  logic                  i_is_end,
  input  logic [SCORE_W-1:0]    i_score,
  input  logic [24*N_LAYERS-1:0] i_layer_rgb,
  input  logic [N_LAYERS-1:0]   i_layer_hit,
  output logic [SCORE_W-1:0]    o_tally_value,
  output logic [SCORE_W-1:0]    o_high_score,
  output logic                  o_new_record,
  output logic                  o_done,
  output logic [7:0]            o_red,
  output logic [7:0]            o_green,
  output logic [7:0]            o_blue,
  output logic                  o_sprite_hit
);
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  state_t               r_state, w_next;
  logic                 r_vs_q, r_end_q;
  logic [SCORE_W-1:0]   r_score_q, r_tally, r_high;
  logic                 r_new_rec, r_done, r_blink_ph;
  logic [CNT_W-1:0]     r_blink_cnt;

  logic                 w_tick, w_end_rise;
  logic [SCORE_W:0]     w_sum;
  logic [SCORE_W-1:0]   w_tally_nxt;
  logic [N_LAYERS-1:0]  w_vis;
  logic [23:0]          w_rgb;

  assign w_tick     = i_v_sync & ~r_vs_q;
  assign w_end_rise = i_is_end & ~r_end_q;

  // One extra bit so the step can never wrap past the target.
  assign w_sum       = {1'b0, r_tally} + (SCORE_W+1)'(TALLY_STEP);
  assign w_tally_nxt = (w_sum >= {1'b0, r_score_q}) ? r_score_q : w_sum[SCORE_W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_end_rise) w_next = ST_LATCH;
      ST_LATCH: w_next = ST_TALLY;
      ST_TALLY: if (r_tally == r_score_q) w_next = ST_SHOW;
      ST_SHOW:  w_next = ST_SHOW;
      default:  w_next = ST_IDLE;
    endcase
    // Game-over dropping wins over everything else.
    if (r_state != ST_IDLE && !i_is_end) w_next = ST_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vs_q      <= 1'b0;
      r_end_q     <= 1'b0;
      r_score_q   <= '0;
      r_tally     <= '0;
      r_high      <= '0;
      r_new_rec   <= 1'b0;
      r_done      <= 1'b0;
      r_blink_ph  <= 1'b0;
      r_blink_cnt <= '0;
    end else begin
      r_vs_q  <= i_v_sync;
      r_end_q <= i_is_end;
      r_done  <= (w_next == ST_SHOW);
      case (r_state)
        ST_LATCH: if (i_is_end) begin
          r_score_q <= i_score;
          r_tally   <= '0;
          if (i_score > r_high) begin
            r_high    <= i_score;
            r_new_rec <= 1'b1;
          end else begin
            r_new_rec <= 1'b0;
          end
        end
        ST_TALLY: begin
          if (w_tick) r_tally <= w_tally_nxt;
          if (w_next == ST_SHOW) begin
            r_blink_ph  <= 1'b1;
            r_blink_cnt <= '0;
          end
        end
        ST_SHOW: if (w_tick) begin
          if (r_blink_cnt == CNT_W'(BLINK_FRAMES-1)) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= ~r_blink_ph;
          end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
          end
        end
        default: ;
      endcase
      if (w_next == ST_IDLE) r_tally <= '0;
    end
  end

  always_comb begin
    w_vis = '0;
    for (int k = 0; k < N_LAYERS; k++) begin
      if (k == LYR_TALLY)      w_vis[k] = (r_state == ST_TALLY) || (r_state == ST_SHOW);
      else if (k == LYR_HIGH)  w_vis[k] = (r_state == ST_SHOW);
      else if (k == LYR_BADGE) w_vis[k] = (r_state == ST_SHOW) && r_new_rec && r_blink_ph;
      else                     w_vis[k] = (r_state != ST_IDLE);
    end
  end

  layer_priority_mux #(.N_LAYERS(N_LAYERS)) u_mux (
    .i_hit (i_layer_hit),
    .i_vis (w_vis),
    .i_rgb (i_layer_rgb),
    .o_rgb (w_rgb),
    .o_hit (o_sprite_hit)
  );

  assign o_red         = w_rgb[23:16];
  assign o_green       = w_rgb[15:8];
  assign o_blue        = w_rgb[7:0];
  assign o_tally_value = r_tally;
  assign o_high_score  = r_high;
  assign o_new_record  = r_new_rec;
  assign o_done        = r_done;
endmodule
